// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multi-cycle CPU's unified port.
// A request is accepted in IDLE. The responder waits WAIT_STATES cycles and
// then performs the access. It returns a one-cycle response carrying the read
// data and an error flag. The block also owns the memory-mapped Cause register.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write/addr/wdata    request payload, held by requester until accepted
//   resp_valid              one-cycle response pulse
//   resp_rdata/resp_err     response payload, meaningful while resp_valid=1
//   cause_we/cause_code     control-unit load of the Cause register
//   cause_q                 current Cause register value
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] CAUSE_ADDR  = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        cause_we,
    input  logic [31:0] cause_code,
    output logic [31:0] cause_q
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW        = 4;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    req_t            req_q;
    logic            accept_c;
    logic            access_c;

    logic [31:0]     mem [DEPTH_WORDS];

    // Address decode of the latched request
    logic            misaligned_c;
    logic            cause_hit_c;
    logic            ram_hit_c;
    logic            err_c;
    logic [AW-1:0]   ram_idx_c;
    logic [31:0]     rdata_c;
    logic            ram_we_c;
    logic            cause_store_c;

    // Next-state logic: wait-state countdown between acceptance and access
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        access_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    cnt_d    = CW'(WAIT_STATES);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    access_c = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= (state_d == IDLE);
            resp_valid <= (state_d == RESP);
        end
    end

    // Request capture at acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= '0;
        end else if (accept_c) begin
            req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        end
    end

    // Decode: misalignment dominates, then Cause, then RAM range
    always_comb begin
        misaligned_c  = |req_q.addr[1:0];
        cause_hit_c   = (req_q.addr == CAUSE_ADDR);
        ram_hit_c     = (req_q.addr < RAM_BYTES);
        err_c         = misaligned_c | (!cause_hit_c && !ram_hit_c);
        ram_idx_c     = req_q.addr[AW+1:2];
        ram_we_c      = access_c && req_q.write && !err_c && !cause_hit_c;
        cause_store_c = access_c && req_q.write && !err_c && cause_hit_c;
        rdata_c       = '0;
        if (!err_c && !req_q.write) begin
            rdata_c = cause_hit_c ? cause_q : mem[ram_idx_c];
        end
    end

    // Response payload, held until the next access edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (access_c) begin
            resp_rdata <= rdata_c;
            resp_err   <= err_c;
        end
    end

    // Cause register: the control-unit strobe wins over a bus store on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q <= '0;
        end else if (cause_we) begin
            cause_q <= cause_code;
        end else if (cause_store_c) begin
            cause_q <= req_q.wdata;
        end
    end

    // RAM array, not reset
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[ram_idx_c] <= req_q.wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (W=2, W=0, W=3) driven one at a time.
// Stimulus pushes required responses into a queue. A negedge monitor pops and
// compares them whenever a DUT raises resp_valid.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        reset_n, req_valid, req_ready, req_write;
    logic [2:0]        resp_valid, resp_err, cause_we;
    logic [2:0][31:0]  req_addr, req_wdata, resp_rdata, cause_code, cause_q;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(512),
            .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3)),
            .CAUSE_ADDR (32'h0000_0800)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g]),
            .cause_we  (cause_we[g]),
            .cause_code(cause_code[g]),
            .cause_q   (cause_q[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [2:0] prev_rv = '0;

    function automatic int w_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (reset_n[d] === 1'b1) begin
                if (prev_rv[d]) check1("pulse_width", resp_valid[d], 1'b0);
                if (resp_valid[d] === 1'b1) begin
                    check1("ready_low_in_resp", req_ready[d], 1'b0);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: dut %0d rdata %h err %b at cycle %0d, no response required",
                                 d, resp_rdata[d], resp_err[d], cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.dut != d || mon_e.rdata !== resp_rdata[d] ||
                            mon_e.err !== resp_err[d] || mon_e.cyc != cyc) begin
                            errors++;
                            $display("FAIL %s: got dut %0d rdata %h err %b cycle %0d, want dut %0d rdata %h err %b cycle %0d",
                                     mon_e.name, d, resp_rdata[d], resp_err[d], cyc,
                                     mon_e.dut, mon_e.rdata, mon_e.err, mon_e.cyc);
                        end
                    end
                end
            end
            prev_rv[d] <= resp_valid[d] & reset_n[d];
        end
    end

    // Issue one request from a negedge; returns at the negedge after acceptance
    task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string name, input bit hold,
                          input bit expect_resp, output int acc);
        int   n;
        exp_t e;
        n = 0;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: req_ready stayed 0 for %0d cycles, required 1", name, n);
            req_valid[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (expect_resp) begin
            e.dut   = d;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = acc + 1 + w_of(d);
            e.name  = name;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid[d] = 1'b0;
        check1({name, "_busy_ready"}, req_ready[d], 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic req(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input string name);
        int acc;
        do_req(d, wr, addr, wdata, exp_rdata, exp_err, name, 1'b0, 1'b1, acc);
        wait_drain(name);
    endtask

    initial begin
        int a0, a1, a2;
        reset_n    = '0;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        cause_we   = '0;
        cause_code = '0;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check1("rst_ready", req_ready[d], 1'b1);
            check1("rst_valid", resp_valid[d], 1'b0);
            check32("rst_rdata", resp_rdata[d], 32'h0);
            check1("rst_err", resp_err[d], 1'b0);
            check32("rst_cause", cause_q[d], 32'h0);
        end
        reset_n = '1;
        @(negedge clk);

        // W=2: store then load, response timing checked by the monitor
        req(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_10");
        req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_10");

        // Faulting accesses leave RAM untouched
        req(0, 1'b1, 32'h12, 32'h55, 32'h0, 1'b1, "st_misaligned");
        req(0, 1'b1, 32'h1000, 32'h66, 32'h0, 1'b1, "st_out_of_range");
        req(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "ld_misaligned");
        req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_10_after_err");

        // cause_we on the same edge as a bus store to Cause
        do_req(0, 1'b1, 32'h800, 32'h1, 32'h0, 1'b0, "st_cause_collide", 1'b0, 1'b1, a0);
        @(negedge clk);
        @(negedge clk);
        cause_we[0]   = 1'b1;
        cause_code[0] = 32'h2;
        @(negedge clk);
        cause_we[0]   = 1'b0;
        check32("cause_we_wins", cause_q[0], 32'h2);
        wait_drain("st_cause_collide");
        req(0, 1'b0, 32'h800, 32'h0, 32'h2, 1'b0, "ld_cause");

        // cause_we while idle
        cause_we[0]   = 1'b1;
        cause_code[0] = 32'h1;
        @(negedge clk);
        cause_we[0]   = 1'b0;
        check32("cause_idle", cause_q[0], 32'h1);
        check1("cause_idle_ready", req_ready[0], 1'b1);
        check1("cause_idle_novalid", resp_valid[0], 1'b0);

        // W=0: preload, then back-to-back loads with req_valid held
        req(1, 1'b1, 32'h0, 32'h1, 32'h0, 1'b0, "pre_0");
        req(1, 1'b1, 32'h4, 32'h2, 32'h0, 1'b0, "pre_4");
        req(1, 1'b1, 32'h8, 32'h3, 32'h0, 1'b0, "pre_8");
        do_req(1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, "b2b_ld_0", 1'b1, 1'b1, a0);
        do_req(1, 1'b0, 32'h4, 32'h0, 32'h2, 1'b0, "b2b_ld_4", 1'b1, 1'b1, a1);
        do_req(1, 1'b0, 32'h8, 32'h0, 32'h3, 1'b0, "b2b_ld_8", 1'b0, 1'b1, a2);
        check32("b2b_spacing_1", 32'(a1 - a0), 32'd3);
        check32("b2b_spacing_2", 32'(a2 - a1), 32'd3);
        wait_drain("b2b");
        req(1, 1'b1, 32'h800, 32'h5A, 32'h0, 1'b0, "bus_st_cause");
        check32("bus_st_cause_q", cause_q[1], 32'h5A);
        req(1, 1'b0, 32'h800, 32'h0, 32'h5A, 1'b0, "bus_ld_cause");

        // W=3: reset in the middle of a store
        cause_we[2]   = 1'b1;
        cause_code[2] = 32'h77;
        @(negedge clk);
        cause_we[2]   = 1'b0;
        check32("cause_pre_reset", cause_q[2], 32'h77);
        req(2, 1'b1, 32'h20, 32'h1234, 32'h0, 1'b0, "pre_20");
        do_req(2, 1'b1, 32'h20, 32'hAAAA, 32'h0, 1'b0, "st_dropped", 1'b0, 1'b0, a0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n[2] = 1'b0;
        #1;
        check1("midrst_ready", req_ready[2], 1'b1);
        check1("midrst_valid", resp_valid[2], 1'b0);
        check32("midrst_cause", cause_q[2], 32'h0);
        repeat (3) @(negedge clk);
        reset_n[2] = 1'b1;
        repeat (8) @(negedge clk);
        check1("postrst_ready", req_ready[2], 1'b1);
        req(2, 1'b0, 32'h20, 32'h0, 32'h1234, 1'b0, "ld_20_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
